// File: rtl/issue_select.sv
// issue_select: picks up to two ready reservation-station entries per cycle
// with a rotating priority pointer, applies MUL/LDST structural limits and
// the LDST occupancy window, and registers the issued instructions as the
// issue stage that feeds the scoreboard broadcast.
module issue_select #(
   parameter int RS_ENT      = 16,
   parameter int RS_IDX      = 4,
   parameter int PHY_REG_SEL = 6,
   parameter int TYPE_W      = 2,
   parameter int LDST_OCC    = 2,
   parameter logic [TYPE_W-1:0] TYPE_MUL  = 2'd2,
   parameter logic [TYPE_W-1:0] TYPE_LDST = 2'd3
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush,
   input  logic [RS_ENT-1:0]             req,
   input  logic [RS_ENT*TYPE_W-1:0]      ent_type,
   input  logic [RS_ENT*PHY_REG_SEL-1:0] ent_dst,
   input  logic [RS_ENT-1:0]             ent_wr_reg,
   output logic [RS_ENT-1:0]             grant_1,
   output logic [RS_ENT-1:0]             grant_2,
   output logic                          inst_issued_1,
   output logic                          inst_issued_2,
   output logic [PHY_REG_SEL-1:0]        bc_dst_1,
   output logic [PHY_REG_SEL-1:0]        bc_dst_2,
   output logic                          iss_valid_1,
   output logic                          iss_valid_2,
   output logic [RS_IDX-1:0]             iss_idx_1,
   output logic [RS_IDX-1:0]             iss_idx_2,
   output logic [TYPE_W-1:0]             iss_type_1,
   output logic [TYPE_W-1:0]             iss_type_2,
   output logic                          ldst_busy
);

   localparam int CNT_W = $clog2(LDST_OCC + 1);

   logic [RS_IDX-1:0] ptr_r;
   logic [CNT_W-1:0]  ldst_cnt_r;

   logic [RS_ENT-1:0] elig_s;
   logic              found1_s;
   logic              found2_s;
   logic [RS_IDX-1:0] win1_s;
   logic [RS_IDX-1:0] win2_s;
   logic [RS_IDX-1:0] idx1_s;
   logic [RS_IDX-1:0] idx2_s;
   logic [TYPE_W-1:0] typ1_s;
   logic [TYPE_W-1:0] typ2_s;
   logic [TYPE_W-1:0] cand_typ_s;
   logic              ldst_take_s;

   // Eligible set: ready entries, minus LDST while the unit is occupied; empty on flush or reset.
   always_comb begin
      elig_s = '0;
      for (int i = 0; i < RS_ENT; i++) begin
         if (reset || flush) begin
            elig_s[i] = 1'b0;
         end else if ((ldst_cnt_r != '0) && (ent_type[i*TYPE_W +: TYPE_W] == TYPE_LDST)) begin
            elig_s[i] = 1'b0;
         end else begin
            elig_s[i] = req[i];
         end
      end
   end

   // Port 1 winner: first eligible entry scanning circularly from the pointer.
   always_comb begin
      found1_s = 1'b0;
      win1_s   = '0;
      idx1_s   = '0;
      for (int k = 0; k < RS_ENT; k++) begin
         idx1_s = ptr_r + RS_IDX'(k);
         if (!found1_s && elig_s[idx1_s]) begin
            found1_s = 1'b1;
            win1_s   = idx1_s;
         end else begin
            found1_s = found1_s;
         end
      end
      typ1_s = ent_type[win1_s*TYPE_W +: TYPE_W];
   end

   // Port 2 winner: next eligible entry after port 1, excluding a second MUL or LDST.
   always_comb begin
      found2_s   = 1'b0;
      win2_s     = '0;
      idx2_s     = '0;
      cand_typ_s = '0;
      for (int k = 1; k < RS_ENT; k++) begin
         idx2_s     = win1_s + RS_IDX'(k);
         cand_typ_s = ent_type[idx2_s*TYPE_W +: TYPE_W];
         if (!found1_s || found2_s || !elig_s[idx2_s]) begin
            found2_s = found2_s;
         end else if ((typ1_s == TYPE_MUL) && (cand_typ_s == TYPE_MUL)) begin
            found2_s = found2_s;
         end else if ((typ1_s == TYPE_LDST) && (cand_typ_s == TYPE_LDST)) begin
            found2_s = found2_s;
         end else begin
            found2_s = 1'b1;
            win2_s   = idx2_s;
         end
      end
      typ2_s = ent_type[win2_s*TYPE_W +: TYPE_W];
   end

   // One-hot grants back to the RS and the LDST-issue indication.
   always_comb begin
      grant_1         = '0;
      grant_2         = '0;
      grant_1[win1_s] = found1_s;
      grant_2[win2_s] = found2_s;
      ldst_take_s     = (found1_s && (typ1_s == TYPE_LDST)) ||
                        (found2_s && (typ2_s == TYPE_LDST));
   end

   assign ldst_busy = (ldst_cnt_r != '0);

   // Rotating pointer and LDST occupancy counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_r      <= '0;
         ldst_cnt_r <= '0;
      end else begin
         if (found2_s) begin
            ptr_r <= win2_s + RS_IDX'(1);
         end else if (found1_s) begin
            ptr_r <= win1_s + RS_IDX'(1);
         end else begin
            ptr_r <= ptr_r;
         end
         if (ldst_take_s) begin
            ldst_cnt_r <= CNT_W'(LDST_OCC);
         end else if (ldst_cnt_r != '0) begin
            ldst_cnt_r <= ldst_cnt_r - CNT_W'(1);
         end else begin
            ldst_cnt_r <= ldst_cnt_r;
         end
      end
   end

   // Issue-stage registers; with no grant the valid/issued flags and fields load zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         iss_valid_1   <= 1'b0;
         iss_valid_2   <= 1'b0;
         inst_issued_1 <= 1'b0;
         inst_issued_2 <= 1'b0;
         bc_dst_1      <= '0;
         bc_dst_2      <= '0;
         iss_idx_1     <= '0;
         iss_idx_2     <= '0;
         iss_type_1    <= '0;
         iss_type_2    <= '0;
      end else begin
         iss_valid_1   <= found1_s;
         iss_valid_2   <= found2_s;
         inst_issued_1 <= found1_s & ent_wr_reg[win1_s];
         inst_issued_2 <= found2_s & ent_wr_reg[win2_s];
         bc_dst_1      <= found1_s ? ent_dst[win1_s*PHY_REG_SEL +: PHY_REG_SEL] : '0;
         bc_dst_2      <= found2_s ? ent_dst[win2_s*PHY_REG_SEL +: PHY_REG_SEL] : '0;
         iss_idx_1     <= found1_s ? win1_s : '0;
         iss_idx_2     <= found2_s ? win2_s : '0;
         iss_type_1    <= found1_s ? typ1_s : '0;
         iss_type_2    <= found2_s ? typ2_s : '0;
      end
   end

endmodule

// File: tb/tb_issue_select.sv
// Directed bench for issue_select: table of single-cycle vectors applied in
// sequence from reset (pointer state carried forward by hand), followed by a
// hand-written LDST occupancy sequence and a mid-window reset.
module tb_issue_select;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic [15:0] req;
   logic [31:0] ent_type;
   logic [95:0] ent_dst;
   logic [15:0] ent_wr_reg;
   logic [15:0] grant_1, grant_2;
   logic        inst_issued_1, inst_issued_2;
   logic [5:0]  bc_dst_1, bc_dst_2;
   logic        iss_valid_1, iss_valid_2;
   logic [3:0]  iss_idx_1, iss_idx_2;
   logic [1:0]  iss_type_1, iss_type_2;
   logic        ldst_busy;

   int n_checks = 0;
   int n_errors = 0;

   issue_select dut (
      .clk(clk), .reset(reset), .flush(flush), .req(req),
      .ent_type(ent_type), .ent_dst(ent_dst), .ent_wr_reg(ent_wr_reg),
      .grant_1(grant_1), .grant_2(grant_2),
      .inst_issued_1(inst_issued_1), .inst_issued_2(inst_issued_2),
      .bc_dst_1(bc_dst_1), .bc_dst_2(bc_dst_2),
      .iss_valid_1(iss_valid_1), .iss_valid_2(iss_valid_2),
      .iss_idx_1(iss_idx_1), .iss_idx_2(iss_idx_2),
      .iss_type_1(iss_type_1), .iss_type_2(iss_type_2),
      .ldst_busy(ldst_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] req;
      logic [31:0] etype;
      logic [15:0] wr;
      logic        flush;
      logic [15:0] g1;
      logic [15:0] g2;
      logic        v1;
      logic        v2;
      logic        is1;
      logic        is2;
      logic [5:0]  d1;
      logic [5:0]  d2;
      logic [3:0]  ptr;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] oh2idx(input logic [15:0] oh);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (oh[i]) r = 4'(i);
      end
      return r;
   endfunction

   initial begin
      logic [3:0] ix;
      // entry i destination tag = 4*i+1 (entry 1 -> 5, entry 2 -> 9)
      for (int i = 0; i < 16; i++) ent_dst[i*6 +: 6] = 6'(i*4 + 1);
      // types: ALU=0 BRANCH=1 MUL=2 LDST=3
      //          req       etype         wr        fl    g1        g2        v1 v2 is1 is2 d1     d2     ptr
      vecs[0] = '{16'h0006, 32'h00000000, 16'hFFFF, 1'b0, 16'h0002, 16'h0004, 1, 1, 1, 1, 6'd5,  6'd9,  4'd3};
      vecs[1] = '{16'h0003, 32'h0000000A, 16'hFFFF, 1'b0, 16'h0001, 16'h0000, 1, 0, 1, 0, 6'd1,  6'd0,  4'd1};
      vecs[2] = '{16'h0002, 32'h0000000A, 16'hFFFF, 1'b0, 16'h0002, 16'h0000, 1, 0, 1, 0, 6'd5,  6'd0,  4'd2};
      vecs[3] = '{16'h0008, 32'h00000040, 16'hFFF7, 1'b0, 16'h0008, 16'h0000, 1, 0, 0, 0, 6'd13, 6'd0,  4'd4};
      vecs[4] = '{16'h2000, 32'h00000000, 16'hFFFF, 1'b0, 16'h2000, 16'h0000, 1, 0, 1, 0, 6'd53, 6'd0,  4'd14};
      vecs[5] = '{16'h8001, 32'h00000000, 16'hFFFF, 1'b0, 16'h8000, 16'h0001, 1, 1, 1, 1, 6'd61, 6'd1,  4'd1};
      vecs[6] = '{16'hFFFF, 32'h00000000, 16'hFFFF, 1'b1, 16'h0000, 16'h0000, 0, 0, 0, 0, 6'd0,  6'd0,  4'd1};
      vecs[7] = '{16'h0000, 32'h00000000, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 0, 0, 0, 0, 6'd0,  6'd0,  4'd1};

      reset = 1'b1; flush = 1'b0; req = 16'hFFFF; ent_type = '0; ent_wr_reg = 16'hFFFF;
      #2;
      check("reset_grant_1", grant_1, 0);
      check("reset_grant_2", grant_2, 0);
      check("reset_valid_1", iss_valid_1, 0);
      check("reset_bc_dst_2", bc_dst_2, 0);
      check("reset_busy", ldst_busy, 0);
      @(posedge clk); @(negedge clk);
      req = '0;
      reset = 1'b0;

      for (int v = 0; v < 8; v++) begin
         @(negedge clk);
         req = vecs[v].req; ent_type = vecs[v].etype;
         ent_wr_reg = vecs[v].wr; flush = vecs[v].flush;
         #1;
         check($sformatf("v%0d_grant_1", v), grant_1, vecs[v].g1);
         check($sformatf("v%0d_grant_2", v), grant_2, vecs[v].g2);
         @(posedge clk); #1;
         check($sformatf("v%0d_iss_valid_1", v), iss_valid_1, vecs[v].v1);
         check($sformatf("v%0d_iss_valid_2", v), iss_valid_2, vecs[v].v2);
         check($sformatf("v%0d_inst_issued_1", v), inst_issued_1, vecs[v].is1);
         check($sformatf("v%0d_inst_issued_2", v), inst_issued_2, vecs[v].is2);
         check($sformatf("v%0d_bc_dst_1", v), bc_dst_1, vecs[v].d1);
         check($sformatf("v%0d_bc_dst_2", v), bc_dst_2, vecs[v].d2);
         check($sformatf("v%0d_ptr", v), dut.ptr_r, vecs[v].ptr);
         if (vecs[v].v1) begin
            ix = oh2idx(vecs[v].g1);
            check($sformatf("v%0d_iss_idx_1", v), iss_idx_1, ix);
            check($sformatf("v%0d_iss_type_1", v), iss_type_1, vecs[v].etype[ix*2 +: 2]);
         end
      end

      // LDST window: ptr=1, entries 1 and 2 LDST, entry 5 ALU
      @(negedge clk);
      flush = 1'b0; ent_type = 32'h0000003C; ent_wr_reg = 16'hFFFF; req = 16'h0006;
      #1;
      check("ld_t_grant_1", grant_1, 16'h0002);
      check("ld_t_grant_2", grant_2, 16'h0000);
      @(posedge clk); #1;
      check("ld_t_iss_type_1", iss_type_1, 2'd3);
      check("ld_t1_busy", ldst_busy, 1);
      @(negedge clk);
      req = 16'h0024;
      #1;
      check("ld_t1_grant_1", grant_1, 16'h0020);
      check("ld_t1_grant_2", grant_2, 16'h0000);
      @(posedge clk); #1;
      check("ld_t2_busy", ldst_busy, 1);
      @(negedge clk);
      req = 16'h0004;
      #1;
      check("ld_t2_grant_1", grant_1, 16'h0000);
      @(posedge clk); #1;
      check("ld_t3_busy", ldst_busy, 0);
      @(negedge clk);
      #1;
      check("ld_t3_grant_1", grant_1, 16'h0004);
      @(posedge clk); #1;
      check("ld_t4_busy", ldst_busy, 1);
      check("ld_t4_iss_idx_1", iss_idx_1, 4'd2);

      // reset in the middle of the LDST window clears everything at once
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid_reset_busy", ldst_busy, 0);
      check("mid_reset_grant_1", grant_1, 16'h0000);
      check("mid_reset_valid_1", iss_valid_1, 0);
      check("mid_reset_ptr", dut.ptr_r, 4'd0);
      @(negedge clk);
      reset = 1'b0; req = '0;
      @(posedge clk); #1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
